// File: rtl/escape_iter_engine_if.sv
// Handshake bundle for escape_iter_engine: point input (c, max_iter) and result output.
// master = upstream/downstream side, slave = engine side.
interface escape_iter_engine_if #(
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int ITER_WIDTH        = 16
);
  logic                                in_valid;
  logic                                in_ready;
  logic signed [ENGINE_DATA_WIDTH-1:0] cr;
  logic signed [ENGINE_DATA_WIDTH-1:0] ci;
  logic        [ITER_WIDTH-1:0]        max_iter;
  logic                                out_valid;
  logic                                out_ready;
  logic        [ITER_WIDTH-1:0]        iter_count;
  logic                                escaped;

  modport master (
    output in_valid, cr, ci, max_iter, out_ready,
    input  in_ready, out_valid, iter_count, escaped
  );

  modport slave (
    input  in_valid, cr, ci, max_iter, out_ready,
    output in_ready, out_valid, iter_count, escaped
  );
endinterface

// File: rtl/escape_iter_engine.sv
// Fixed-point escape-time engine: iterates z <- z^2 + c from z = 0 until |z|^2 > 4 or max_iter.
// Optional macro CALC_PIPE_REG_EN registers the products, giving a two-cycle iteration.
module escape_iter_engine #(
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int FRAC_BITS         = 21,
  parameter int ITER_WIDTH        = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  escape_iter_engine_if.slave bus
);
  localparam int W  = ENGINE_DATA_WIDTH;
  localparam int PW = 2 * ENGINE_DATA_WIDTH;
  // 4.0 at 2*FRAC_BITS fractional bits; the leading zero keeps it positive after extension.
  localparam logic signed [PW:0] C_LIMIT = $signed({4'b0100, {(2*FRAC_BITS){1'b0}}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2,
    S_ADD  = 2'd3
  } state_t;

`ifdef CALC_PIPE_REG_EN
  localparam state_t S_EVAL = S_ADD;
`else
  localparam state_t S_EVAL = S_ITER;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [W-1:0]   r_zr;
  logic signed [W-1:0]   r_zi;
  logic signed [W-1:0]   r_cr;
  logic signed [W-1:0]   r_ci;
  logic [ITER_WIDTH-1:0] r_max_iter;
  logic [ITER_WIDTH-1:0] r_iter;
  logic [ITER_WIDTH-1:0] r_iter_count;
  logic                  r_escaped;
  logic                  r_in_ready;
  logic                  r_out_valid;

  logic signed [PW-1:0]  w_zr_ext;
  logic signed [PW-1:0]  w_zi_ext;
  logic signed [PW-1:0]  w_p_zr_sq;
  logic signed [PW-1:0]  w_p_zi_sq;
  logic signed [PW-1:0]  w_p_zrzi;
  logic signed [PW-1:0]  w_zr_sq;
  logic signed [PW-1:0]  w_zi_sq;
  logic signed [PW-1:0]  w_zrzi;
  logic signed [PW:0]    w_mag;
  logic signed [PW-1:0]  w_re_full;
  logic signed [PW:0]    w_im_full;
  logic signed [W-1:0]   w_zr_next;
  logic signed [W-1:0]   w_zi_next;
  logic                  w_load;
  logic                  w_step;
  logic                  w_finish;
  logic                  w_esc;

  assign w_zr_ext  = {{W{r_zr[W-1]}}, r_zr};
  assign w_zi_ext  = {{W{r_zi[W-1]}}, r_zi};
  assign w_p_zr_sq = w_zr_ext * w_zr_ext;
  assign w_p_zi_sq = w_zi_ext * w_zi_ext;
  assign w_p_zrzi  = w_zr_ext * w_zi_ext;

`ifdef CALC_PIPE_REG_EN
  logic signed [PW-1:0] r_zr_sq;
  logic signed [PW-1:0] r_zi_sq;
  logic signed [PW-1:0] r_zrzi;

  // Product registers, captured in the MUL sub-state and consumed in ADD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_zr_sq <= '0;
      r_zi_sq <= '0;
      r_zrzi  <= '0;
    end else if (r_state == S_ITER) begin
      r_zr_sq <= w_p_zr_sq;
      r_zi_sq <= w_p_zi_sq;
      r_zrzi  <= w_p_zrzi;
    end
  end

  assign w_zr_sq = r_zr_sq;
  assign w_zi_sq = r_zi_sq;
  assign w_zrzi  = r_zrzi;
`else
  assign w_zr_sq = w_p_zr_sq;
  assign w_zi_sq = w_p_zi_sq;
  assign w_zrzi  = w_p_zrzi;
`endif

  // Compare and update run on the full-precision products; truncation happens after the shift.
  assign w_mag     = {w_zr_sq[PW-1], w_zr_sq} + {w_zi_sq[PW-1], w_zi_sq};
  assign w_re_full = w_zr_sq - w_zi_sq;
  assign w_im_full = $signed({w_zrzi, 1'b0});
  assign w_zr_next = W'(w_re_full >>> FRAC_BITS) + r_cr;
  assign w_zi_next = W'(w_im_full >>> FRAC_BITS) + r_ci;

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_esc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = S_ITER;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ITER, S_ADD: begin
        if (r_state != S_EVAL) begin
          w_state_nxt = S_EVAL;
        end else if (w_mag > C_LIMIT) begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
          w_esc       = 1'b1;
        end else if (r_iter == r_max_iter) begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
          w_esc       = 1'b0;
        end else begin
          w_state_nxt = S_ITER;
          w_step      = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_zr         <= '0;
      r_zi         <= '0;
      r_cr         <= '0;
      r_ci         <= '0;
      r_max_iter   <= '0;
      r_iter       <= '0;
      r_iter_count <= '0;
      r_escaped    <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_load) begin
        r_cr       <= bus.cr;
        r_ci       <= bus.ci;
        r_max_iter <= bus.max_iter;
        r_zr       <= '0;
        r_zi       <= '0;
        r_iter     <= '0;
      end else if (w_step) begin
        r_zr   <= w_zr_next;
        r_zi   <= w_zi_next;
        r_iter <= r_iter + ITER_WIDTH'(1);
      end
      if (w_finish) begin
        r_iter_count <= r_iter;
        r_escaped    <= w_esc;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.iter_count = r_iter_count;
  assign bus.escaped    = r_escaped;
endmodule

// File: tb/tb_escape_iter_engine.sv
// Self-checking bench for escape_iter_engine: directed plan points, handshakes,
// back-to-back throughput and random points against an integer escape-time model.
module tb_escape_iter_engine;
  localparam int W  = 25;
  localparam int F  = 21;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  escape_iter_engine_if #(.ENGINE_DATA_WIDTH(W), .ITER_WIDTH(IW)) bus ();

  escape_iter_engine #(.ENGINE_DATA_WIDTH(W), .FRAC_BITS(F), .ITER_WIDTH(IW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic longint wrap(input longint x);
    longint t;
    t = x & ((longint'(1) << W) - 1);
    if (t >= (longint'(1) << (W - 1))) t = t - (longint'(1) << W);
    return t;
  endfunction

  // Escape-time reference: plain integer arithmetic on the fixed-point values.
  function automatic void model(input int cr, input int ci, input int mx,
                                output int cnt, output bit esc);
    longint zr = 0, zi = 0, nr, ni;
    longint lim = longint'(4) << (2 * F);
    cnt = 0;
    esc = 1'b0;
    for (int it = 0; it <= mx; it++) begin
      if (zr * zr + zi * zi > lim) begin
        cnt = it; esc = 1'b1; return;
      end
      if (it == mx) begin
        cnt = mx; esc = 1'b0; return;
      end
      nr = ((zr * zr - zi * zi) >>> F) + cr;
      ni = ((2 * zr * zi) >>> F) + ci;
      zr = wrap(nr);
      zi = wrap(ni);
    end
  endfunction

  function automatic int exp_latency(input int k);
`ifdef CALC_PIPE_REG_EN
    return 2 * (k + 1);
`else
    return k + 1;
`endif
  endfunction

  task automatic run_point(input string name, input int cr, input int ci, input int mx);
    int k; bit e; int cyc;
    model(cr, ci, mx, k, e);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %b want 1", name, bus.in_ready);
    end
    bus.cr = W'(cr); bus.ci = W'(ci); bus.max_iter = IW'(mx); bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 2 * mx + 20) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc != exp_latency(k)) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_latency(k));
    end
    checks++;
    if (bus.iter_count !== IW'(k)) begin
      errors++; $display("FAIL %s iter_count: got %0d want %0d", name, bus.iter_count, k);
    end
    checks++;
    if (bus.escaped !== e) begin
      errors++; $display("FAIL %s escaped: got %b want %b", name, bus.escaped, e);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s turnaround: out_valid=%b in_ready=%b want 0/1",
                         name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.cr = '0; bus.ci = '0; bus.max_iter = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    if (bus.iter_count !== '0) begin errors++; $display("FAIL reset iter_count: got %0d want 0", bus.iter_count); end
    if (bus.escaped !== 1'b0) begin errors++; $display("FAIL reset escaped: got %b want 0", bus.escaped); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_iter();
    @(negedge clk);
    bus.cr = '0; bus.ci = '0; bus.max_iter = IW'(1000); bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset busy: in_ready=%b want 0", bus.in_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset in_ready: got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b want 0", bus.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    run_point("after_reset", 2097152, 0, 100);
  endtask

  task automatic test_directed();
    run_point("zero_c_50", 0, 0, 50);
    run_point("one_0", 2097152, 0, 100);
    run_point("minus_two", -4194304, 0, 20);
    run_point("three_max0", 6291456, 0, 0);
    run_point("three_max10", 6291456, 0, 10);
    run_point("i_axis", 0, 2097152, 30);
  endtask

  task automatic test_handshake();
    int ka, kb; bit ea, eb; int cyc;
    model(2097152, 0, 100, ka, ea);
    model(0, 0, 5, kb, eb);
    @(negedge clk);
    bus.cr = W'(2097152); bus.ci = '0; bus.max_iter = IW'(100); bus.in_valid = 1'b1;
    @(negedge clk);
    bus.cr = '0; bus.ci = '0; bus.max_iter = IW'(5);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.iter_count !== IW'(ka) || bus.escaped !== ea) begin
        errors++;
        $display("FAIL hold cycle %0d: valid=%b ready=%b count=%0d esc=%b want 1/0/%0d/%b",
                 i, bus.out_valid, bus.in_ready, bus.iter_count, bus.escaped, ka, ea);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL consume: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL next_accept: in_ready=%b want 0", bus.in_ready);
    end
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    checks += 3;
    if (cyc != exp_latency(kb)) begin errors++; $display("FAIL held_point latency: got %0d want %0d", cyc, exp_latency(kb)); end
    if (bus.iter_count !== IW'(kb)) begin errors++; $display("FAIL held_point count: got %0d want %0d", bus.iter_count, kb); end
    if (bus.escaped !== eb) begin errors++; $display("FAIL held_point escaped: got %b want %b", bus.escaped, eb); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k; bit e; int hits[$]; int period;
    model(2097152, 0, 100, k, e);
    period = exp_latency(k) + 2;
    @(negedge clk);
    bus.cr = W'(2097152); bus.ci = '0; bus.max_iter = IW'(100);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && hits.size() < 3; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        hits.push_back(c);
        checks++;
        if (bus.iter_count !== IW'(k) || bus.escaped !== e) begin
          errors++; $display("FAIL b2b result: count=%0d esc=%b want %0d/%b", bus.iter_count, bus.escaped, k, e);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (hits.size() != 3) begin
      errors++; $display("FAIL b2b results seen: got %0d want 3", hits.size());
    end else begin
      checks++;
      if (hits[1] - hits[0] != period || hits[2] - hits[1] != period) begin
        errors++; $display("FAIL b2b period: got %0d,%0d want %0d", hits[1] - hits[0], hits[2] - hits[1], period);
      end
    end
    repeat (2 * period) @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int cr, ci, mx;
    for (int n = 0; n < 25; n++) begin
      cr = int'($urandom_range(0, 8388608)) - 4194304;
      ci = int'($urandom_range(0, 8388608)) - 4194304;
      mx = int'($urandom_range(0, 40));
      run_point($sformatf("rand%0d", n), cr, ci, mx);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_iter();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/escape_iter_engine.md
# escape_iter_engine

Iteration engine that produces the zr_next/zi_next feedback consumed by the engine's z-register stage. It accepts one complex point c over a valid/ready handshake and iterates z ← z² + c in fixed point from z = 0. It returns the escape iteration count and an escaped flag over a second valid/ready handshake. It sits between the pixel/coordinate generator and the colour mapper in the fractal pipeline.

## Interface
- ENGINE_DATA_WIDTH, 25: signed two's-complement width of cr, ci, zr, zi.
- FRAC_BITS, 21: fractional bits. Default format is Q4.21, so 1.0 = 0x200000.
- ITER_WIDTH, 16: width of max_iter and iter_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  c and max_iter are valid.
- in_ready  out  1  engine idle and able to accept a point.
- cr  in  ENGINE_DATA_WIDTH  real part of c, signed.
- ci  in  ENGINE_DATA_WIDTH  imaginary part of c, signed.
- max_iter  in  ITER_WIDTH  iteration limit, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- iter_count  out  ITER_WIDTH  final iteration index.
- escaped  out  1  1 means |z|² > 4 was reached; 0 means the limit was hit.

## Operation
- FSM states: IDLE, ITER, DONE. Reset state is IDLE.
- Reset values: in_ready = 1, out_valid = 0, iter_count = 0, escaped = 0. Internal zr, zi, cr, ci and iter registers reset to 0.
- IDLE:
  - in_ready = 1.
  - Accept occurs when in_valid && in_ready at a clock edge.
  - On accept: latch cr, ci and max_iter; set z = 0 and iter = 0; go to ITER.
- ITER: one evaluation per cycle, in priority order:
  1. If zr² + zi² > 4.0: iter_count = iter, escaped = 1, go to DONE.
  2. Else if iter == max_iter: iter_count = max_iter, escaped = 0, go to DONE.
  3. Else: z ← z² + c, iter ← iter + 1.
- DONE:
  - out_valid = 1; iter_count and escaped are held stable.
  - When out_ready is high at an edge, go to IDLE.
  - in_ready stays 0 until IDLE is re-entered, so there is no overlap with the next point.
- Arithmetic:
  - Squares and the cross product are computed at full 2×ENGINE_DATA_WIDTH precision.
  - The magnitude compare is (zr² + zi²) > (4 << 2·FRAC_BITS) at 2×ENGINE_DATA_WIDTH+1 bits. No truncation before the compare.
  - zr_next = ((zr² − zi²) >>> FRAC_BITS) + cr.
  - zi_next = ((2·zr·zi) >>> FRAC_BITS) + ci.
  - The shift is arithmetic (floor) and the result is truncated to ENGINE_DATA_WIDTH.
  - No overflow is possible. z is advanced only when |z| ≤ 2, and only when |c| ≤ 2 after iteration 1, so every component stays ≤ 6 < 8.
- max_iter = 0 returns count 0, escaped 0.
- The iter counter never wraps, because step 2 terminates at max_iter.
- in_valid while busy is ignored. The point is not consumed, so the upstream holds it.

## Timing
- Let k be the final iter_count. Without the macro, out_valid rises k+1 edges after the accepting edge.
- Minimum turnaround:
  - out_ready held high: out_valid lasts 1 cycle, then in_ready is 1 in the next cycle.
  - Throughput is one point per k+3 cycles.
- Asserting reset mid-ITER or mid-DONE immediately (asynchronously) forces IDLE values. Any in-flight result is discarded with no partial out_valid.
- out_ready asserted in ITER or IDLE has no effect.

## Configuration
- CALC_PIPE_REG_EN defined:
  - ITER splits into sub-states MUL and ADD.
  - zr², zi² and zr·zi are registered in MUL. The compare and update happen in ADD.
  - Each iteration takes 2 cycles, and out_valid rises 2(k+1) edges after accept.
  - Results are bit-identical to the single-cycle build.
- Not defined: single-cycle ITER as above.

## Test plan
- Reset mid-ITER (c = 0, max_iter = 1000, reset at cycle 10) -> out_valid = 0 and in_ready = 1 immediately. A new point is then accepted normally.
- c = 0, max_iter = 50 -> iter_count = 50, escaped = 0, out_valid 51 edges after accept (102 with CALC_PIPE_REG_EN).
- cr = 0x200000 (1.0), ci = 0, max_iter = 100 -> z runs 1, 2, 5. Result iter_count = 3, escaped = 1, out_valid 4 edges after accept.
- cr = 0x1C00000 (−2.0), ci = 0, max_iter = 20 -> exact |z|² = 4 boundary, never escapes. Result iter_count = 20, escaped = 0.
- cr = 0x600000 (3.0), max_iter = 0 -> iter_count = 0, escaped = 0. Same c with max_iter = 10 -> iter_count = 1, escaped = 1.
- Handshakes:
  - Hold out_ready = 0 for 5 cycles after out_valid. Result stays stable and in_ready stays 0 with in_valid held high.
  - Then raise out_ready. The next point is accepted exactly 1 cycle after the result is consumed.
